// File: rtl/pipe_pkg.sv
// Shared constants, stage action encoding and the saturating counter helper
// used by the generic pipeline stage register.
package pipe_pkg;

  localparam int          DEF_DATA_W = 64;
  localparam int          DEF_CNT_W  = 16;
  localparam int          MAX_CNT_W  = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [DEF_DATA_W-1:0] FLUSH_DEF = '0;

  // What the stage does on the coming edge, already priority-resolved
  typedef enum logic [2:0] {
    ACT_FREEZE,
    ACT_IDLE,
    ACT_FLUSH,
    ACT_STALL,
    ACT_ADVANCE
  } stage_act_e;

  // Increment cnt, sticking at the all-ones value of a width-bit counter
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] cnt,
                                                   input int unsigned          width);
    logic [MAX_CNT_W-1:0] top;
    top = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - width);
    return (cnt >= top) ? top : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register: catches the payload accepted while the stage
// output is stalled so that upstream ready can come straight from flops.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic              vld,
  output logic [DATA_W-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      dout <= FLUSH_VAL;
    end else if (clear) begin
      vld  <= 1'b0;
      dout <= FLUSH_VAL;
    end else if (load) begin
      vld  <= 1'b1;
      dout <= din;
    end else if (drain) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register (IF/ID, ID/EX, ...) with start gating,
// flush, local stall, global freeze, optional skid buffer and perf counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
  parameter bit                 SKID_EN   = 1'b1,
  parameter int                 CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic              start_o,
  input  logic              mem_stall_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              start_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              skid_vld_p1;
  logic [DATA_W-1:0] skid_data_p1;
  logic [CNT_W-1:0]  stall_cnt_p1;
  logic [CNT_W-1:0]  bubble_cnt_p1;
  logic              stall_act;
  logic              accept;
  stage_act_e        act;

  // An empty stage never blocks, so a stall only bites when the output is valid
  assign stall_act = stall_i & vld_p1;
  assign accept    = valid_i & ready_o;

  always_comb begin
    act = ACT_ADVANCE;
    if (mem_stall_i)              act = ACT_FREEZE;
    else if (!start_p1 && !start_i) act = ACT_IDLE;
    else if (flush_i)             act = ACT_FLUSH;
    else if (stall_act)           act = ACT_STALL;
  end

  generate
    if (SKID_EN) begin : g_skid
      logic skid_load;
      logic skid_drain;
      logic skid_clear;

      assign skid_load  = (act == ACT_STALL) & accept;
      assign skid_drain = (act == ACT_ADVANCE) & skid_vld_p1;
      assign skid_clear = (act == ACT_FLUSH);

      pipe_skid_buf #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL)
      ) u_skid (
        .clk   (clk),
        .rst_n (rst_n_i),
        .load  (skid_load),
        .drain (skid_drain),
        .clear (skid_clear),
        .din   (data_i),
        .vld   (skid_vld_p1),
        .dout  (skid_data_p1)
      );

      // Only flops and the global freeze feed ready; stall_i does not
      assign ready_o = start_p1 & ~skid_vld_p1 & ~mem_stall_i;
    end else begin : g_noskid
      assign skid_vld_p1  = 1'b0;
      assign skid_data_p1 = FLUSH_VAL;
      assign ready_o      = start_p1 & ~mem_stall_i & (~stall_i | ~vld_p1);
    end
  endgenerate

  // Stage output register
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      start_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      data_p1  <= FLUSH_VAL;
    end else begin
      case (act)
        ACT_FREEZE, ACT_IDLE: ;
        ACT_FLUSH: begin
          start_p1 <= 1'b1;
          vld_p1   <= 1'b0;
          data_p1  <= FLUSH_VAL;
        end
        ACT_STALL: begin
          start_p1 <= 1'b1;
        end
        ACT_ADVANCE: begin
          start_p1 <= 1'b1;
          if (skid_vld_p1) begin
            vld_p1  <= 1'b1;
            data_p1 <= skid_data_p1;
          end else begin
            vld_p1  <= accept;
            data_p1 <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Performance counters: frozen with the pipe, clear beats increment
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_p1  <= '0;
      bubble_cnt_p1 <= '0;
    end else if (!mem_stall_i) begin
      if (cnt_clr_i) begin
        stall_cnt_p1  <= '0;
        bubble_cnt_p1 <= '0;
      end else begin
        if (stall_act)
          stall_cnt_p1 <= CNT_W'(sat_inc(MAX_CNT_W'(stall_cnt_p1), CNT_W));
        if (start_p1 && !vld_p1)
          bubble_cnt_p1 <= CNT_W'(sat_inc(MAX_CNT_W'(bubble_cnt_p1), CNT_W));
      end
    end
  end

  assign start_o      = start_p1;
  assign valid_o      = vld_p1;
  assign data_o       = data_p1;
  assign stall_cnt_o  = stall_cnt_p1;
  assign bubble_cnt_o = bubble_cnt_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: instance A uses the skid buffer with 16-bit counters,
// instance B has no skid, 4-bit counters and a small queue reference model.
module tb_pipe_stage_reg;

  localparam logic [63:0] A_FLUSH = 64'hF1F1_0000_F1F1;
  localparam logic [63:0] B_FLUSH = 64'h0000_0000_0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_i;

  logic        a_start_i, a_start_o, a_mem_stall_i, a_valid_i, a_ready_o;
  logic        a_stall_i, a_flush_i, a_valid_o, a_cnt_clr_i;
  logic [63:0] a_data_i, a_data_o;
  logic [15:0] a_stall_cnt_o, a_bubble_cnt_o;

  logic        b_start_i, b_start_o, b_mem_stall_i, b_valid_i, b_ready_o;
  logic        b_stall_i, b_flush_i, b_valid_o, b_cnt_clr_i;
  logic [63:0] b_data_i, b_data_o;
  logic [3:0]  b_stall_cnt_o, b_bubble_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  logic        m_started, m_vld;
  logic [63:0] m_data;
  logic [3:0]  m_stall, m_bub;
  logic [63:0] ref_q[$];

  pipe_stage_reg #(
    .DATA_W(64), .FLUSH_VAL(A_FLUSH), .SKID_EN(1'b1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n_i(rst_n_i), .start_i(a_start_i), .start_o(a_start_o),
    .mem_stall_i(a_mem_stall_i), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .data_i(a_data_i), .stall_i(a_stall_i), .flush_i(a_flush_i),
    .valid_o(a_valid_o), .data_o(a_data_o), .cnt_clr_i(a_cnt_clr_i),
    .stall_cnt_o(a_stall_cnt_o), .bubble_cnt_o(a_bubble_cnt_o)
  );

  pipe_stage_reg #(
    .DATA_W(64), .FLUSH_VAL(B_FLUSH), .SKID_EN(1'b0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n_i(rst_n_i), .start_i(b_start_i), .start_o(b_start_o),
    .mem_stall_i(b_mem_stall_i), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .data_i(b_data_i), .stall_i(b_stall_i), .flush_i(b_flush_i),
    .valid_o(b_valid_o), .data_o(b_data_o), .cnt_clr_i(b_cnt_clr_i),
    .stall_cnt_o(b_stall_cnt_o), .bubble_cnt_o(b_bubble_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on instance B, checked against the queue model
  task automatic b_step(input logic v, input logic [63:0] d, input logic s);
    logic m_rdy, held, acc;
    b_valid_i = v;
    b_data_i  = d;
    b_stall_i = s;
    #1;
    m_rdy = m_started & ~(s & m_vld);
    chk("b_ready", 64'(b_ready_o), 64'(m_rdy));
    held = s & m_vld;
    acc  = v & m_rdy;
    if (acc) ref_q.push_back(d);
    if (held && m_stall != 4'hF) m_stall++;
    if (m_started && !m_vld && m_bub != 4'hF) m_bub++;
    tick();
    if (!held) begin
      m_vld = acc;
      if (acc) m_data = ref_q.pop_front();
    end
    chk("b_valid", 64'(b_valid_o), 64'(m_vld));
    if (m_vld) chk("b_data", b_data_o, m_data);
    chk("b_stall_cnt", 64'(b_stall_cnt_o), 64'(m_stall));
    chk("b_bubble_cnt", 64'(b_bubble_cnt_o), 64'(m_bub));
  endtask

  initial begin
    rst_n_i = 1'b1;
    a_start_i = 0; a_mem_stall_i = 0; a_valid_i = 0; a_data_i = '0;
    a_stall_i = 0; a_flush_i = 0; a_cnt_clr_i = 0;
    b_start_i = 0; b_mem_stall_i = 0; b_valid_i = 0; b_data_i = '0;
    b_stall_i = 0; b_flush_i = 0; b_cnt_clr_i = 0;
    m_started = 0; m_vld = 0; m_data = '0; m_stall = '0; m_bub = '0;

    #2 rst_n_i = 1'b0;
    #1;
    chk("a_rst_valid", 64'(a_valid_o), 64'd0);
    chk("a_rst_data", a_data_o, A_FLUSH);
    chk("a_rst_start", 64'(a_start_o), 64'd0);
    chk("a_rst_ready", 64'(a_ready_o), 64'd0);
    chk("a_rst_stall_cnt", 64'(a_stall_cnt_o), 64'd0);
    chk("b_rst_data", b_data_o, B_FLUSH);
    tick();
    rst_n_i = 1'b1;
    tick();

    // A: start gating
    a_valid_i = 1; a_data_i = 64'hA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_gate_valid", 64'(a_valid_o), 64'd0);
      chk("a_gate_ready", 64'(a_ready_o), 64'd0);
    end
    a_start_i = 1;
    tick();
    chk("a_start_o", 64'(a_start_o), 64'd1);
    chk("a_start_ready", 64'(a_ready_o), 64'd1);
    chk("a_start_valid", 64'(a_valid_o), 64'd0);
    tick();
    chk("a_first_valid", 64'(a_valid_o), 64'd1);
    chk("a_first_data", a_data_o, 64'hA);
    chk("a_first_bubble", 64'(a_bubble_cnt_o), 64'd1);

    // A: stall with skid capture
    a_data_i = 64'd1;
    tick();
    chk("a_s1_data", a_data_o, 64'd1);
    a_data_i = 64'd2; a_stall_i = 1;
    tick();
    chk("a_s2_data_hold", a_data_o, 64'd1);
    chk("a_s2_valid", 64'(a_valid_o), 64'd1);
    chk("a_s2_ready", 64'(a_ready_o), 64'd0);
    chk("a_s2_stall_cnt", 64'(a_stall_cnt_o), 64'd1);
    a_data_i = 64'd3;
    tick();
    chk("a_s3_data_hold", a_data_o, 64'd1);
    chk("a_s3_ready", 64'(a_ready_o), 64'd0);
    chk("a_s3_stall_cnt", 64'(a_stall_cnt_o), 64'd2);
    a_stall_i = 0;
    tick();
    chk("a_rel_data2", a_data_o, 64'd2);
    chk("a_rel_valid", 64'(a_valid_o), 64'd1);
    chk("a_rel_ready", 64'(a_ready_o), 64'd1);
    tick();
    chk("a_rel_data3", a_data_o, 64'd3);
    a_data_i = 64'd4;
    tick();
    chk("a_rel_data4", a_data_o, 64'd4);
    a_valid_i = 0;
    tick();
    chk("a_drain_valid", 64'(a_valid_o), 64'd0);
    chk("a_drain_stall_cnt", 64'(a_stall_cnt_o), 64'd2);
    chk("a_drain_bubble", 64'(a_bubble_cnt_o), 64'd1);

    // A: flush during stall with a full skid
    a_valid_i = 1; a_data_i = 64'd5;
    tick();
    chk("a_f_data5", a_data_o, 64'd5);
    a_data_i = 64'd6; a_stall_i = 1;
    tick();
    chk("a_f_skid_full_ready", 64'(a_ready_o), 64'd0);
    chk("a_f_data_hold", a_data_o, 64'd5);
    a_data_i = 64'd7; a_flush_i = 1;
    tick();
    chk("a_f_valid", 64'(a_valid_o), 64'd0);
    chk("a_f_data", a_data_o, A_FLUSH);
    chk("a_f_ready", 64'(a_ready_o), 64'd1);
    chk("a_f_stall_cnt", 64'(a_stall_cnt_o), 64'd4);
    a_flush_i = 0; a_stall_i = 0; a_valid_i = 0; a_data_i = '0;
    tick();
    chk("a_f_skid_empty", 64'(a_valid_o), 64'd0);
    chk("a_f_bubble", 64'(a_bubble_cnt_o), 64'd3);

    // A: global freeze amid traffic
    a_valid_i = 1; a_data_i = 64'd8;
    tick();
    chk("a_m_data8", a_data_o, 64'd8);
    chk("a_m_bubble", 64'(a_bubble_cnt_o), 64'd4);
    a_mem_stall_i = 1; a_data_i = 64'd9; a_cnt_clr_i = 1;
    #1;
    chk("a_m_ready_comb", 64'(a_ready_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      a_flush_i = (i % 2 == 0);
      a_stall_i = (i % 2 == 1);
      tick();
      chk("a_m_valid", 64'(a_valid_o), 64'd1);
      chk("a_m_data", a_data_o, 64'd8);
      chk("a_m_ready", 64'(a_ready_o), 64'd0);
      chk("a_m_stall_cnt", 64'(a_stall_cnt_o), 64'd4);
      chk("a_m_bubble_cnt", 64'(a_bubble_cnt_o), 64'd4);
      chk("a_m_start", 64'(a_start_o), 64'd1);
    end
    a_mem_stall_i = 0; a_flush_i = 0; a_stall_i = 0; a_cnt_clr_i = 0; a_valid_i = 0;
    tick();
    chk("a_m_after_valid", 64'(a_valid_o), 64'd0);
    chk("a_m_after_stall_cnt", 64'(a_stall_cnt_o), 64'd4);
    chk("a_m_after_bubble", 64'(a_bubble_cnt_o), 64'd4);

    // A: asynchronous reset mid-stream
    a_valid_i = 1; a_data_i = 64'hB;
    tick();
    chk("a_r_dataB", a_data_o, 64'hB);
    a_data_i = 64'hC; a_stall_i = 1;
    tick();
    #1 rst_n_i = 1'b0;
    #1;
    chk("a_r_valid", 64'(a_valid_o), 64'd0);
    chk("a_r_data", a_data_o, A_FLUSH);
    chk("a_r_start", 64'(a_start_o), 64'd0);
    chk("a_r_stall_cnt", 64'(a_stall_cnt_o), 64'd0);
    chk("a_r_bubble_cnt", 64'(a_bubble_cnt_o), 64'd0);
    a_valid_i = 0; a_stall_i = 0; a_start_i = 0;
    tick();
    rst_n_i = 1'b1;
    tick();
    chk("a_r_idle_start", 64'(a_start_o), 64'd0);
    chk("a_r_idle_ready", 64'(a_ready_o), 64'd0);
    a_start_i = 1;
    tick();
    tick();
    chk("a_r_skid_lost", 64'(a_valid_o), 64'd0);
    chk("a_r_ready", 64'(a_ready_o), 64'd1);

    // B: start gating without skid
    b_valid_i = 1; b_data_i = 64'hA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_gate_valid", 64'(b_valid_o), 64'd0);
      chk("b_gate_ready", 64'(b_ready_o), 64'd0);
    end
    b_start_i = 1;
    tick();
    chk("b_start_o", 64'(b_start_o), 64'd1);
    chk("b_start_ready", 64'(b_ready_o), 64'd1);
    tick();
    chk("b_first_valid", 64'(b_valid_o), 64'd1);
    chk("b_first_data", b_data_o, 64'hA);
    m_started = 1; m_vld = 1; m_data = 64'hA; m_bub = 4'd1; m_stall = 4'd0;

    // B: stream against the queue model
    b_step(1, 64'd1, 0);
    b_step(1, 64'd2, 1);
    b_step(1, 64'd2, 1);
    b_step(1, 64'd2, 0);
    b_step(1, 64'd3, 0);
    b_step(1, 64'd4, 1);
    b_step(1, 64'd4, 0);
    b_step(0, 64'd0, 0);
    b_step(0, 64'd0, 1);
    b_step(1, 64'd5, 0);
    for (int i = 0; i < 20; i++) b_step(0, 64'd0, 1);
    chk("b_stall_sat", 64'(b_stall_cnt_o), 64'hF);

    // B: clear beats a simultaneous stall increment
    b_cnt_clr_i = 1; b_stall_i = 1;
    tick();
    chk("b_clr_stall_cnt", 64'(b_stall_cnt_o), 64'd0);
    chk("b_clr_bubble_cnt", 64'(b_bubble_cnt_o), 64'd0);
    b_cnt_clr_i = 0;

    // B: flush overrides stall, then freeze drops ready
    b_flush_i = 1;
    tick();
    chk("b_f_valid", 64'(b_valid_o), 64'd0);
    chk("b_f_data", b_data_o, B_FLUSH);
    b_flush_i = 0; b_stall_i = 0;
    #1;
    chk("b_f_ready", 64'(b_ready_o), 64'd1);
    b_mem_stall_i = 1;
    #1;
    chk("b_m_ready", 64'(b_ready_o), 64'd0);
    b_mem_stall_i = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
